// File: rtl/video_pkg.sv
// Shared video constants: RGB565 field layout, default geometry, counter helpers.
package video_pkg;
  localparam int RGB_W   = 16;
  localparam int R_MSB   = 15;
  localparam int R_LSB   = 11;
  localparam int G_MSB   = 10;
  localparam int G_LSB   = 5;
  localparam int B_MSB   = 4;
  localparam int B_LSB   = 0;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [CNT_W-1:0] IMG_HDISP_DEF = 10'd640;
  localparam logic [CNT_W-1:0] IMG_VDISP_DEF = 10'd480;

  // Saturating increment: geometry counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/cmos_capture_rgb565_if.sv
// DVP camera inputs and per_frame_* pixel stream of the capture block.
interface cmos_capture_rgb565_if;
  import video_pkg::*;

  logic             cmos_vsync;
  logic             cmos_href;
  logic [7:0]       cmos_data;
  logic             cmos_frame_vsync;
  logic             cmos_frame_href;
  logic             cmos_frame_clken;
  logic [RGB_W-1:0] cmos_frame_data;
  logic             cmos_frame_done;
  logic             line_err;
  logic             frame_err;

  // master: the capture block (consumes DVP, produces the pixel stream)
  modport master (
    input  cmos_vsync, cmos_href, cmos_data,
    output cmos_frame_vsync, cmos_frame_href, cmos_frame_clken,
           cmos_frame_data, cmos_frame_done, line_err, frame_err
  );

  // slave: camera/sink side
  modport slave (
    output cmos_vsync, cmos_href, cmos_data,
    input  cmos_frame_vsync, cmos_frame_href, cmos_frame_clken,
           cmos_frame_data, cmos_frame_done, line_err, frame_err
  );
endinterface

// File: rtl/cmos_sync_edge.sv
// Two-stage input register for a sync line plus active-level and edge pulses.
module cmos_sync_edge #(
  parameter logic ACT_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic act,
  output logic rise,
  output logic fall
);
  logic r1, r2, r3;

  // r1/r2 resynchronise; r3 holds the previous r2 for edge detection.
  // Reset to the inactive level so an idle line produces no spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= ~ACT_LVL;
      r2 <= ~ACT_LVL;
      r3 <= ~ACT_LVL;
    end else begin
      r1 <= din;
      r2 <= r1;
      r3 <= r2;
    end
  end

  assign act  = (r2 == ACT_LVL);
  assign rise = act & (r3 != ACT_LVL);
  assign fall = ~act & (r3 == ACT_LVL);
endmodule

// File: rtl/cmos_capture_rgb565.sv
// DVP capture: skips unstable frames, packs byte pairs into RGB565 and
// checks line/frame geometry of every frame it forwards.
module cmos_capture_rgb565 import video_pkg::*; #(
  parameter logic             CMOS_VSYNC_VALID = 1'b1,
  parameter logic [CNT_W-1:0] IMG_HDISP        = IMG_HDISP_DEF,
  parameter logic [CNT_W-1:0] IMG_VDISP        = IMG_VDISP_DEF,
  parameter logic [3:0]       FRAME_SKIP       = 4'd10
) (
  input  logic clk,
  input  logic rst,
  cmos_capture_rgb565_if.master bus
);
  logic             vs_act, vs_rise, vs_fall;
  logic             hr, hr_rise, hr_fall;
  logic [7:0]       d_r1, d_r2, hi_byte;
  logic             phase, gate, gate_open, frame_ok;
  logic [3:0]       skip_cnt;
  logic [CNT_W-1:0] h_cnt, v_cnt, v_cnt_eff;
  logic             pix_en, line_end, frame_end, line_bad;

  cmos_sync_edge #(.ACT_LVL(CMOS_VSYNC_VALID)) u_vs (
    .clk(clk), .rst(rst), .din(bus.cmos_vsync),
    .act(vs_act), .rise(vs_rise), .fall(vs_fall)
  );

  cmos_sync_edge #(.ACT_LVL(1'b1)) u_hr (
    .clk(clk), .rst(rst), .din(bus.cmos_href),
    .act(hr), .rise(hr_rise), .fall(hr_fall)
  );

  // Gate is treated as open already in the frame-start cycle so the first
  // active vsync cycle of the first forwarded frame is not lost.
  assign frame_ok  = (skip_cnt == FRAME_SKIP);
  assign gate_open = gate | (vs_rise & frame_ok);
  assign pix_en    = hr & phase & vs_act & gate_open;
  // A line ends on href fall inside the frame, or is cut short when vsync
  // drops while href is (or was just) high.
  assign line_end  = gate_open & ((hr_fall & vs_act) | (vs_fall & (hr | hr_fall)));
  assign frame_end = gate_open & vs_fall;
  assign line_bad  = phase | (h_cnt != IMG_HDISP);
  assign v_cnt_eff = line_end ? sat_inc(v_cnt) : v_cnt;

  // Data path shares the two-stage latency of the sync lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r1 <= '0;
      d_r2 <= '0;
    end else begin
      d_r1 <= bus.cmos_data;
      d_r2 <= d_r1;
    end
  end

  // Byte phase runs on every href-high cycle (even outside the frame); high byte latched on phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= 1'b0;
      hi_byte <= '0;
    end else begin
      phase <= hr ? ~phase : 1'b0;
      if (hr && !phase) hi_byte <= d_r2;
    end
  end

  // Frame skip counter and output gate; gate only opens on a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt <= '0;
      gate     <= 1'b0;
    end else begin
      if (vs_fall && (skip_cnt < FRAME_SKIP)) skip_cnt <= skip_cnt + 4'd1;
      if (vs_rise && frame_ok) gate <= 1'b1;
    end
  end

  // Geometry counters; pixels per line and lines per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (line_end || hr_rise) h_cnt <= '0;
      else if (pix_en)         h_cnt <= sat_inc(h_cnt);
      if (frame_end) v_cnt <= '0;
      else           v_cnt <= v_cnt_eff;
    end
  end

  // Registered outputs and sticky geometry error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmos_frame_vsync <= 1'b0;
      bus.cmos_frame_href  <= 1'b0;
      bus.cmos_frame_clken <= 1'b0;
      bus.cmos_frame_data  <= '0;
      bus.cmos_frame_done  <= 1'b0;
      bus.line_err         <= 1'b0;
      bus.frame_err        <= 1'b0;
    end else begin
      bus.cmos_frame_vsync <= vs_act & gate_open;
      bus.cmos_frame_href  <= hr & gate_open;
      bus.cmos_frame_clken <= pix_en;
      if (pix_en) bus.cmos_frame_data <= {hi_byte, d_r2};
      bus.cmos_frame_done  <= frame_end;
      if (line_end && line_bad)                      bus.line_err  <= 1'b1;
      if (frame_end && (v_cnt_eff != IMG_VDISP))     bus.frame_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Scoreboard bench: two captures (vsync active-high and active-low with
// inverted vsync) fed the same DVP stream must both match a frame-level model.
module tb_cmos_capture_rgb565;
  import video_pkg::*;

  localparam logic [9:0] HD = 10'd16;
  localparam logic [9:0] VD = 10'd5;
  localparam logic [3:0] SK = 4'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vs = 1'b0, hr = 1'b0;
  logic [7:0] dat = 8'h00;

  cmos_capture_rgb565_if b0 ();
  cmos_capture_rgb565_if b1 ();

  assign b0.cmos_vsync = vs;
  assign b0.cmos_href  = hr;
  assign b0.cmos_data  = dat;
  assign b1.cmos_vsync = ~vs;
  assign b1.cmos_href  = hr;
  assign b1.cmos_data  = dat;

  cmos_capture_rgb565 #(.CMOS_VSYNC_VALID(1'b1), .IMG_HDISP(HD), .IMG_VDISP(VD), .FRAME_SKIP(SK))
    dut0 (.clk(clk), .rst(rst), .bus(b0.master));
  cmos_capture_rgb565 #(.CMOS_VSYNC_VALID(1'b0), .IMG_HDISP(HD), .IMG_VDISP(VD), .FRAME_SKIP(SK))
    dut1 (.clk(clk), .rst(rst), .bus(b1.master));

  logic [1:0]  o_vs, o_hr, o_ck, o_dn, o_le, o_fe;
  logic [15:0] o_d [2];
  assign o_vs = {b1.cmos_frame_vsync, b0.cmos_frame_vsync};
  assign o_hr = {b1.cmos_frame_href,  b0.cmos_frame_href};
  assign o_ck = {b1.cmos_frame_clken, b0.cmos_frame_clken};
  assign o_dn = {b1.cmos_frame_done,  b0.cmos_frame_done};
  assign o_le = {b1.line_err,         b0.line_err};
  assign o_fe = {b1.frame_err,        b0.frame_err};
  assign o_d[0] = b0.cmos_frame_data;
  assign o_d[1] = b1.cmos_frame_data;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] d; longint c; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int checks = 0, errors = 0;
  int n_dn[2] = '{0, 0};
  int n_vs[2] = '{0, 0};
  int n_hr[2] = '{0, 0};

  // model state
  bit m_gate = 1'b0;
  int m_fend = 0;
  int exp_dn = 0, exp_vs = 0, exp_hr = 0;
  bit exp_le = 1'b0, exp_fe = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every clken and tallies output activity.
  task automatic mon(input int k);
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_dn[k] = 0; n_vs[k] = 0; n_hr[k] = 0;
      end else begin
        n_vs[k] += int'(o_vs[k]);
        n_hr[k] += int'(o_hr[k]);
        n_dn[k] += int'(o_dn[k]);
        if (o_ck[k]) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("dut%0d_unexpected_pixel", k), 1, 0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d_pix_data", k), longint'(o_d[k]), longint'(e.d));
            chk($sformatf("dut%0d_pix_cycle", k), cyc, e.c);
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  // One input cycle: account model activity for the values now driven, then step.
  task automatic cyc1();
    if (vs && m_gate) exp_vs++;
    if (hr && m_gate) exp_hr++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    chk("queue_empty_before_reset", q0.size() + q1.size(), 0);
    m_gate = 1'b0; m_fend = 0;
    exp_dn = 0; exp_vs = 0; exp_hr = 0; exp_le = 1'b0; exp_fe = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_reset_outs", k),
          longint'({o_vs[k], o_hr[k], o_ck[k], o_dn[k], o_le[k], o_fe[k]}), 0);
      chk($sformatf("dut%0d_reset_data", k), longint'(o_d[k]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Frame: nl lines; odd_ln has 2*HD-1 bytes; rst_ln resets before that line;
  // cut_ln (last line) drops vsync after 10 bytes with href still high.
  // patt 0: incrementing bytes, 1: random, 2: A5,3C then random.
  task automatic frame(input int nl, input int odd_ln, input int patt,
                       input int rst_ln, input int cut_ln);
    logic [7:0] b [64];
    bit en;
    int nb, vcnt, pix;
    vcnt = 0;
    vs = 1'b1;
    if (m_fend >= int'(SK)) m_gate = 1'b1;
    en = m_gate;
    repeat (3) cyc1();
    for (int l = 0; l < nl; l++) begin
      if (l == rst_ln) begin do_reset(); en = m_gate; end
      nb = (l == odd_ln) ? 2*int'(HD) - 1 : 2*int'(HD);
      for (int i = 0; i < nb; i++) begin
        b[i] = (patt == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      end
      if (patt == 2) begin b[0] = 8'hA5; b[1] = 8'h3C; end
      hr = 1'b1;
      for (int i = 0; i < nb; i++) begin
        if (l == cut_ln && i == 10) vs = 1'b0;
        dat = b[i];
        if (en && vs && (i % 2 == 1)) begin
          q0.push_back('{d: {b[i-1], b[i]}, c: cyc + 3});
          q1.push_back('{d: {b[i-1], b[i]}, c: cyc + 3});
        end
        cyc1();
      end
      hr = 1'b0; dat = 8'h00;
      if (en) begin
        vcnt++;
        pix = (l == cut_ln) ? 5 : nb / 2;
        if ((nb % 2 == 1 && l != cut_ln) || pix != int'(HD)) exp_le = 1'b1;
      end
      repeat (4) cyc1();
    end
    vs = 1'b0;
    if (en) begin
      exp_dn++;
      if (vcnt != int'(VD)) exp_fe = 1'b1;
    end
    m_fend++;
    repeat (8) cyc1();
  endtask

  task automatic chkpt(input string nm);
    repeat (4) cyc1();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_dut%0d_done_cnt", nm, k), n_dn[k], exp_dn);
      chk($sformatf("%s_dut%0d_vsync_cycles", nm, k), n_vs[k], exp_vs);
      chk($sformatf("%s_dut%0d_href_cycles", nm, k), n_hr[k], exp_hr);
      chk($sformatf("%s_dut%0d_line_err", nm, k), longint'(o_le[k]), longint'(exp_le));
      chk($sformatf("%s_dut%0d_frame_err", nm, k), longint'(o_fe[k]), longint'(exp_fe));
    end
    chk($sformatf("%s_pixels_pending", nm), q0.size() + q1.size(), 0);
  endtask

  initial begin
    do_reset();
    frame(5, -1, 0, -1, -1);
    frame(5, -1, 0, -1, -1);
    chkpt("skip");
    frame(5, -1, 0, -1, -1);
    chkpt("frame3");
    frame(5, -1, 0, -1, -1);
    frame(5, -1, 2, -1, -1);
    frame(5, -1, 1, -1, -1);
    chkpt("pack");
    frame(4, -1, 1, -1, -1);
    chkpt("short");
    frame(5, -1, 1, 1, -1);
    chkpt("midreset");
    frame(5, -1, 1, -1, -1);
    chkpt("postreset_skip");
    frame(5, 2, 1, -1, -1);
    chkpt("odd");
    frame(5, -1, 1, -1, 4);
    chkpt("cut");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
